fetch_stage: RTL and testbench



---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_skid_buffer.sv | 61 ++++++
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: access sizes, reset PC,
// FSM states and the skid-buffer entry layout.
package fetch_pkg;

  localparam logic [1:0] ACC_BYTE = 2'b00;
  localparam logic [1:0] ACC_HALF = 2'b01;
  localparam logic [1:0] ACC_WORD = 2'b10;

  localparam logic [31:0] INSN_BASE = 32'h8002_0000;
  localparam logic [31:0] PC_RESET  = INSN_BASE;

  typedef enum logic {
    StIdle,
    StRun
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Control, memory-read and decode-handshake signals of the fetch stage.
interface fetch_stage_if;

  logic        start;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] mem_address;
  logic [1:0]  mem_access_size;
  logic        mem_write;
  logic [31:0] mem_data_out;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        insn_valid;
  logic        running;

  modport master (
    input  start, stall, redirect, redirect_pc, mem_data_out,
    output mem_address, mem_access_size, mem_write, insn, insn_pc, insn_valid, running
  );

  modport slave (
    output start, stall, redirect, redirect_pc, mem_data_out,
    input  mem_address, mem_access_size, mem_write, insn, insn_pc, insn_valid, running
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// Small circular FIFO of {pc, insn} pairs; flush beats push, head is always visible.
module fetch_skid_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t push_data_i,
  output fetch_entry_t head_o,
  output logic [1:0]   occupancy_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  fetch_entry_t    entries_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0]      count_q, count_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + 2'(push_i) - 2'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) entries_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) entries_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o      = entries_q[rd_ptr_q];
  assign occupancy_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: sequential word reads after start, redirect handling, and a skid
// buffer so a stalled decode never loses a word returning from the 1-cycle memory.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] PcReset  = PC_RESET,
  parameter int unsigned BufDepth = 2
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tag_q, tag_d;
  logic         inflight_q, inflight_d;
  logic         drop_q, drop_d;

  fetch_entry_t head;
  logic [1:0]   occ;
  logic [2:0]   level;
  logic         insn_valid, push, pop, issue;

  assign insn_valid = (occ != 2'd0);
  assign pop        = insn_valid && !bus.stall;
  assign push       = inflight_q && !drop_q;
  // Slots committed after this edge, counting the word decode is taking now.
  assign level      = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue      = (state_q == StRun) && !bus.redirect && (level < 3'(BufDepth));

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = issue;
    // The word landing on the redirect edge is killed by the flush; only a read
    // still outstanding beyond that edge would need dropping.
    drop_d     = bus.redirect && inflight_d;
    if (bus.redirect) begin
      state_d = StRun;
      pc_d    = {bus.redirect_pc[31:2], 2'b00};
    end else if (state_q == StIdle) begin
      if (bus.start) begin
        state_d = StRun;
        pc_d    = PcReset;
      end
    end else if (issue) begin
      tag_d = pc_q;
      pc_d  = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= PcReset;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_skid_buffer #(
    .Depth (BufDepth)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (bus.redirect),
    .push_data_i ({tag_q, bus.mem_data_out}),
    .head_o      (head),
    .occupancy_o (occ)
  );

  assign bus.mem_address     = pc_q;
  assign bus.mem_access_size = ACC_WORD;
  assign bus.mem_write       = 1'b0;
  assign bus.insn            = head.insn;
  assign bus.insn_pc         = head.pc;
  assign bus.insn_valid      = insn_valid;
  assign bus.running         = (state_q == StRun);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench: directed scenarios plus randomized stall/redirect traffic checked
// against an expected-PC sequence model over a loaded memory image.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] image [logic [31:0]];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  function automatic logic [31:0] img(input logic [31:0] a);
    if (image.exists(a)) return image[a];
    return a;
  endfunction

  // Synchronous memory: data for the sampled address appears after the edge.
  always @(posedge clk) bus.mem_data_out <= img(bus.mem_address);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start       = 1'b0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic expect_insn(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(bus.insn_valid), 32'd1);
    check({tag, "_pc"}, bus.insn_pc, pc);
    check({tag, "_insn"}, bus.insn, img(pc));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_pc;
    int unsigned seen, accepted;

    clear_inputs();
    rst = 1'b1;
    image[INSN_BASE]         = 32'h1111_1111;
    image[INSN_BASE + 32'd4] = 32'h2222_2222;
    image[INSN_BASE + 32'd8] = 32'h3333_3333;
    for (int i = 3; i < 600; i++) image[INSN_BASE + 32'(i * 4)] = $urandom;

    // Reset state
    do_reset();
    check("rst_valid", 32'(bus.insn_valid), 32'd0);
    check("rst_running", 32'(bus.running), 32'd0);
    check("rst_addr", bus.mem_address, PC_RESET);
    check("rst_size", 32'(bus.mem_access_size), 32'(ACC_WORD));
    check("rst_write", 32'(bus.mem_write), 32'd0);
    check("rst_insn", bus.insn, 32'd0);
    check("rst_insn_pc", bus.insn_pc, 32'd0);

    // Start latency and back-to-back throughput
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check("t1_lat0", 32'(bus.insn_valid), 32'd0);
    check("t1_running", 32'(bus.running), 32'd1);
    cyc();
    check("t1_lat1", 32'(bus.insn_valid), 32'd0);
    cyc();
    expect_insn("t1_w0", INSN_BASE);
    cyc();
    expect_insn("t1_w1", INSN_BASE + 32'd4);
    cyc();
    expect_insn("t1_w2", INSN_BASE + 32'd8);

    // Stall holds the head; at most two words outstanding; no loss on release
    do_reset();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    cyc();
    bus.stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      expect_insn("t2_hold", INSN_BASE);
      check("t2_depth", 32'((bus.mem_address - bus.insn_pc) <= 32'd8), 32'd1);
    end
    bus.stall = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      expect_insn("t2_seq", INSN_BASE + 32'(4 * k));
    end

    // Redirect with a read in flight
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h8002_0101;
    cyc();
    bus.redirect = 1'b0;
    check("t3_flush0", 32'(bus.insn_valid), 32'd0);
    cyc();
    check("t3_flush1", 32'(bus.insn_valid), 32'd0);
    cyc();
    expect_insn("t3_tgt", 32'h8002_0100);
    cyc();
    expect_insn("t3_next", 32'h8002_0104);

    // Reset mid-stream
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("t4_valid", 32'(bus.insn_valid), 32'd0);
    check("t4_running", 32'(bus.running), 32'd0);
    check("t4_addr", bus.mem_address, PC_RESET);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (bus.insn_valid || bus.running) seen++;
    end
    check("t4_quiet", seen, 32'd0);

    // Redirect from idle across the address wrap
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    cyc();
    bus.redirect = 1'b0;
    cyc();
    cyc();
    expect_insn("t5_w0", 32'hFFFF_FFF8);
    cyc();
    expect_insn("t5_w1", 32'hFFFF_FFFC);
    cyc();
    expect_insn("t5_w2", 32'h0000_0000);

    // Redirect beats start in idle; start in run is ignored
    do_reset();
    bus.start       = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h8002_0040;
    cyc();
    clear_inputs();
    cyc();
    cyc();
    expect_insn("t6_w0", 32'h8002_0040);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    expect_insn("t6_w1", 32'h8002_0044);
    cyc();
    expect_insn("t6_w2", 32'h8002_0048);
    cyc();
    expect_insn("t6_w3", 32'h8002_004C);

    // Randomized stall/redirect/start traffic against the expected-PC sequence
    do_reset();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    exp_pc    = INSN_BASE;
    accepted  = 0;
    for (int i = 0; i < 800; i++) begin
      cyc();
      if (bus.insn_valid) begin
        check("rnd_pc", bus.insn_pc, exp_pc);
        check("rnd_insn", bus.insn, img(exp_pc));
      end
      bus.stall    = ($urandom_range(0, 99) < 30);
      bus.redirect = ($urandom_range(0, 99) < 4);
      bus.start    = ($urandom_range(0, 99) < 3);
      if (bus.redirect) begin
        bus.redirect_pc = INSN_BASE + 32'($urandom_range(0, 400) << 2) + 32'($urandom_range(0, 3));
        exp_pc = {bus.redirect_pc[31:2], 2'b00};
      end else if (bus.insn_valid && !bus.stall) begin
        exp_pc = exp_pc + 32'd4;
        accepted++;
      end
    end
    clear_inputs();
    check("rnd_progress", 32'(accepted >= 200), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
